// File: rtl/hdec_pkg.sv
// hdec_pkg: shared definitions for the hdec_seq registered decoder.
//   - mode encodings driven on the 2-bit mode input (2'b11 behaves as DIRECT)
//   - FSM state enumeration
//   - next_state(): the mode/enable transition table, used by the top level
package hdec_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // SCAN may only be entered while enabled; a disabled SCAN request leaves
  // the current state alone.
  function automatic state_t next_state(state_t cur, logic [1:0] mode, logic en);
    logic   want_direct;
    logic   want_scan;
    logic   want_hold;
    state_t nxt;
    want_direct = (mode == MODE_DIRECT) || (mode == 2'b11);
    want_scan   = (mode == MODE_SCAN) && en;
    want_hold   = (mode == MODE_HOLD);
    nxt         = cur;
    case (cur)
      IDLE:    if (want_direct) nxt = DIRECT;
               else if (want_scan) nxt = SCAN;
      DIRECT:  if (want_scan) nxt = SCAN;
               else if (want_hold) nxt = HOLD;
      SCAN:    if (want_direct) nxt = DIRECT;
               else if (want_hold) nxt = HOLD;
      HOLD:    if (want_direct) nxt = DIRECT;
               else if (want_scan) nxt = SCAN;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/hdec_seq_if.sv
// hdec_seq_if: address channel into the decoder.
//   in_valid : address on w is valid (master -> slave)
//   in_ready : address is taken this cycle when in_valid is high (slave -> master)
//   w        : address to decode (master -> slave)
interface hdec_seq_if #(
  parameter int W = 6
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] w;

  modport master (output in_valid, output w, input in_ready);
  modport slave  (input in_valid, input w, output in_ready);
endinterface

// File: rtl/hdec_seq_onehot.sv
// hdec_onehot: combinational W-to-2^W one-hot decoder with enable.
//   a  : address
//   en : when low all outputs are 0
//   y  : y[i] = en && (a == i)
module hdec_onehot #(
  parameter int W = 6
) (
  input  logic [W-1:0]    a,
  input  logic            en,
  output logic [2**W-1:0] y
);

  generate
    for (genvar gi = 0; gi < 2**W; gi++) begin : g_line
      assign y[gi] = en && (a == W'(gi));
    end
  endgenerate

endmodule

// File: rtl/hdec_seq.sv
// hdec_seq: registered W-to-2^W one-hot decoder with DIRECT, SCAN and HOLD modes.
//   clk, rst   : clock, synchronous active-high reset
//   En         : global enable, low forces y to 0
//   mode       : 00 DIRECT, 01 SCAN, 10 HOLD, 11 DIRECT
//   addr       : address channel (in_valid / in_ready / w), accepted in DIRECT only
//   dwell      : SCAN holds each output for dwell+1 displayed cycles
//   y, y_valid : registered one-hot select and its non-zero flag
//   busy       : FSM is in SCAN
//   scan_wrap  : one-cycle pulse in the cycle output 0 reappears after a wrap
// Optional build macro HDEC_SCAN_LIMIT_EN adds input last[W-1:0]: the scan
// wraps after idx==last (or after 2^W-1 if last is below the current idx).
module hdec_seq
  import hdec_pkg::*;
#(
  parameter int W       = 6,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               En,
  input  logic [1:0]         mode,
  hdec_seq_if.slave          addr,
  input  logic [DWELL_W-1:0] dwell,
`ifdef HDEC_SCAN_LIMIT_EN
  input  logic [W-1:0]       last,
`endif
  output logic [2**W-1:0]    y,
  output logic               y_valid,
  output logic               busy,
  output logic               scan_wrap
);

  localparam logic [W-1:0] IDX_MAX = {W{1'b1}};

  state_t             state_reg, state_next;
  logic [W-1:0]       idx_reg, idx_next;
  logic [DWELL_W-1:0] dcnt_reg, dcnt_next;
  // on_reg: a selection exists (last accepted address had En high, or SCAN is active)
  logic               on_reg, on_next;
  logic [2**W-1:0]    y_reg, y_next;
  logic               y_valid_reg;
  logic               wrap_reg, wrap_next;
  logic               show;
  logic               handshake;
  logic               wrap_point;

  assign addr.in_ready = (state_reg == DIRECT) && !rst;
  assign handshake     = addr.in_valid && addr.in_ready;

`ifdef HDEC_SCAN_LIMIT_EN
  assign wrap_point = (idx_reg == IDX_MAX) || (idx_reg == last);
`else
  assign wrap_point = (idx_reg == IDX_MAX);
`endif

  always_comb begin
    state_next = next_state(state_reg, mode, En);
    idx_next   = idx_reg;
    dcnt_next  = dcnt_reg;
    on_next    = on_reg;
    wrap_next  = 1'b0;
    show       = on_reg && En;

    case (state_reg)
      DIRECT: begin
        if (handshake) begin
          idx_next = addr.w;
          on_next  = En;
        end
        show = on_next && En;
      end
      SCAN: begin
        if (state_next == SCAN) begin
          // Only displayed cycles count toward the dwell, so after a pause the
          // resumed output still gets its full remaining dcnt+1 cycles.
          if (En && y_valid_reg) begin
            if (dcnt_reg == '0) begin
              dcnt_next = dwell;
              if (wrap_point) begin
                idx_next  = '0;
                wrap_next = 1'b1;
              end else begin
                idx_next = idx_reg + 1'b1;
              end
            end else begin
              dcnt_next = dcnt_reg - 1'b1;
            end
          end
          show = En;
        end else if (state_next == DIRECT) begin
          on_next = 1'b0;
          show    = 1'b0;
        end
      end
      default: ;
    endcase

    // Every SCAN entry restarts the sweep at output 0; this overrides a
    // handshake taken in the same DIRECT cycle.
    if ((state_next == SCAN) && (state_reg != SCAN)) begin
      idx_next  = '0;
      dcnt_next = dwell;
      on_next   = 1'b1;
      show      = En;
    end
  end

  // Single decoder, fed by the next index (w on accept, scan index otherwise).
  hdec_onehot #(.W(W)) u_onehot (
    .a  (idx_next),
    .en (show),
    .y  (y_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      dcnt_reg    <= '0;
      on_reg      <= 1'b0;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      wrap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      dcnt_reg    <= dcnt_next;
      on_reg      <= on_next;
      y_reg       <= y_next;
      y_valid_reg <= show;
      wrap_reg    <= wrap_next;
    end
  end

  assign y         = y_reg;
  assign y_valid   = y_valid_reg;
  assign busy      = (state_reg == SCAN);
  assign scan_wrap = wrap_reg;

endmodule

// File: doc/hdec_seq.md
Name: hdec_seq

Overview:
- Parametrised, registered W-to-2^W one-hot decoder.
- Next generation of the team's hierarchical 3-to-8 and 6-to-64 decoders: arbitrary width, registered output, valid/ready address input, and an autonomous scan mode that sweeps the outputs with a programmable dwell time.
- Drives row/bank select lines and scan strobes.

Parameters:
- W, 6, address width; output count is 2**W.
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- En  in  1  global enable; low forces y to 0.
- mode  in  2  00 DIRECT, 01 SCAN, 10 HOLD, 11 treated as DIRECT.
- in_valid  in  1  address valid (DIRECT only).
- in_ready  out  1  address accepted this cycle when in_valid is also high.
- w  in  W  address to decode.
- dwell  in  DWELL_W  SCAN: each output is held for dwell+1 cycles.
- y  out  2**W  registered one-hot (or all-zero) select.
- y_valid  out  1  y holds a non-zero selection.
- busy  out  1  FSM is in SCAN.
- scan_wrap  out  1  one-cycle pulse when the scan index wraps to 0.

Behaviour:
- Reset (rst=1 at an edge): y=0, y_valid=0, busy=0, scan_wrap=0, in_ready=0, state=IDLE, idx=0, dcnt=0. Reset overrides every other input, including mid-scan.
- FSM states:
  - IDLE: go to DIRECT if mode is DIRECT or 11; SCAN if mode=SCAN and En=1; otherwise stay.
  - DIRECT: go to SCAN on mode=SCAN with En=1; HOLD on mode=HOLD.
  - SCAN: go to DIRECT on mode DIRECT/11; HOLD on mode=HOLD.
  - HOLD: go to DIRECT on mode DIRECT/11; SCAN on mode=SCAN with En=1.
  - Transitions are evaluated every cycle.
- in_ready: combinational, =1 only when state=DIRECT and rst=0.
- DIRECT:
  - On in_valid & in_ready, next edge: y <= En ? (1<<w) : 0, y_valid <= En.
  - Latency is 1 cycle. Without a handshake, y keeps its value.
  - Back-to-back accepts every cycle are legal; each produces a new y on the following cycle.
- SCAN:
  - Entry: idx=0, dcnt=dwell, y=1<<0 on the first SCAN cycle.
  - Each cycle with En=1: if dcnt=0, idx advances by 1 and dcnt reloads from dwell; otherwise dcnt decrements.
  - dwell is sampled at each reload.
  - dwell=0 gives a new output every cycle.
  - Wrap: idx 2**W-1 -> 0 pulses scan_wrap for exactly the cycle in which y=1<<0 first appears again.
  - En=0 in SCAN pauses: y=0, y_valid=0, idx and dcnt frozen. When En returns, y=1<<idx and counting resumes at the frozen dcnt.
  - busy=1 for all SCAN cycles, including paused ones.
- HOLD: y, idx and dcnt frozen; handshake not accepted. En=0 still forces y=0; y reappears when En returns.
- Leaving SCAN for DIRECT: y is cleared on the next edge; idx resets to 0 on the next SCAN entry.
- Invariant: y is always one-hot or zero. y_valid = |y, registered alongside y.
- Simultaneous events: a mode change and in_valid in the same cycle are resolved by the current state (the handshake applies only if already in DIRECT).

Optional Feature:
- Macro: HDEC_SCAN_LIMIT_EN.
- With the macro: extra input port last[W-1:0].
  - The scan wraps after idx==last, instead of after 2**W-1.
  - last=0 keeps y on output 0, with scan_wrap pulsing after every dwell period.
  - last is sampled at each wrap decision.
  - If last is lowered below the current idx, the scan runs to 2**W-1 and wraps as normal.
- Without the macro: no port; full 2**W sweep.

Decomposition:
- Package hdec_pkg:
  - mode encoding localparams (MODE_DIRECT=2'b00, MODE_SCAN=2'b01, MODE_HOLD=2'b10);
  - state enum (IDLE, DIRECT, SCAN, HOLD).
- Sub-module hdec_onehot: parametrised combinational W-to-2^W decoder with enable. It replaces the fixed-width decoder tree and is instantiated once, fed by a mux of w and idx.

Test Plan (W=6, DWELL_W=8):
- Reset: rst=1 for 2 cycles with random inputs -> y=0, y_valid=0, busy=0, in_ready=0; one cycle after release with mode=00 -> in_ready=1.
- DIRECT: send w=0, 37, 63 back-to-back with En=1 -> y = bit0, bit37, bit63 on consecutive cycles, each 1 cycle after accept; then w=5 with En=0 -> y=0, y_valid=0.
- SCAN, dwell=2: y steps bit0..bit63 holding 3 cycles each; scan_wrap pulses once, 192 cycles after bit0 first appears, coincident with bit0 reappearing.
- SCAN pause/hold: with idx=10 and dcnt=1, drop En for 5 cycles -> y=0; when En returns, bit10 is held 2 more cycles. mode=HOLD -> y frozen, in_ready=0.
- Mid-scan reset: rst=1 at idx=40 -> next cycle y=0, busy=0; re-entering SCAN starts at bit0.
- HDEC_SCAN_LIMIT_EN, last=3, dwell=0: y cycles bit0, bit1, bit2, bit3, bit0, ...; scan_wrap every 4th cycle.
